masked_bv8_inv_stage3_hpc3: RTL
===============================

MASKED_BV8_INV_STAGE3_HPC3 -- requirements
Module: masked_bv8_inv_stage3_hpc3

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 2, meaning the number of Boolean shares per masked value (NUM_SHARES >= 2).
REQ-002 SHALL have localparam NUM_QUAD, value NUM_SHARES*(NUM_SHARES-1)/2, meaning the number of share-pair cross terms.
REQ-003 SHALL have localparam NUM_RANDOM, value 3*4*NUM_QUAD, meaning the fresh random bits consumed per cycle.
REQ-004 SHALL have port in_clock, input, 1 bit, meaning the single clock; all registers are rising-edge.
REQ-005 SHALL have port in_reset, input, 1 bit, meaning the reset: asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning the stage-2 outputs are valid this cycle.
REQ-007 SHALL have port in_theta_t2, input, bv2_t[NUM_SHARES], meaning the masked GF(2^2) theta from stage 2.
REQ-008 SHALL have port in_mul_a0_t2, input, bv4_t[NUM_SHARES], meaning the masked product a0*d from stage 2.
REQ-009 SHALL have port in_mul_a1_t2, input, bv4_t[NUM_SHARES], meaning the masked product a1*d from stage 2.
REQ-010 SHALL have port in_random, input, NUM_RANDOM bits, packed as {left_p, right_p, joint_r}, each field bv4_t[NUM_QUAD], with joint_r in the LSBs.
REQ-011 SHALL have port out_inv_t3, output, bv8_t[NUM_SHARES], meaning the masked GF(2^8) inverse; per share {b1, b0}, with b1 in the high nibble.
REQ-012 SHALL have port out_valid, output, 1 bit, meaning out_inv_t3 is valid.

Function
REQ-013 SHALL lift theta to GF(2^4) per share as theta4 = {theta, theta}, i.e. the normal-basis embedding of the GF(2^2) subfield; this step is linear and share-wise.
REQ-014 SHALL compute b1 = in_mul_a0_t2 (x) theta4 using an HPC3 masked GF(2^4) multiplier with in_r = joint_r and in_p = left_p.
REQ-015 SHALL compute b0 = in_mul_a1_t2 (x) theta4 using a second HPC3 multiplier with in_r = joint_r and in_p = right_p, sharing joint_r with the first multiplier.
REQ-016 SHALL use the codebase normal-basis GF(2^4) multiplication for (x).
REQ-017 SHALL have a latency of exactly 1 cycle: inputs sampled at edge k appear on out_inv_t3 after edge k; the block is fully pipelined with throughput 1 per cycle.
REQ-018 SHALL clock the multiplier share registers every cycle regardless of in_valid, with no clock or data gating.
REQ-019 SHALL produce out_valid as in_valid registered once; there is no backpressure and no ready signal.
REQ-020 SHALL keep cross-domain terms separated by registers, so that no glitch path combines two shares of one input before the HPC3 register.
REQ-021 SHALL give the unmasked XOR of the out_inv_t3 shares equal to {a0*d*theta, a1*d*theta} for any in_random value.
REQ-022 SHALL, for back-to-back valid inputs, produce back-to-back outputs in order, with no drop and no duplicate.

Reset
REQ-023 SHALL clear all registers while in_reset is 0, asynchronously, so that out_inv_t3 = 0 (all shares) and out_valid = 0.
REQ-024 SHALL, on deassertion of in_reset, resume normal operation; the first out_valid can assert after the first edge that samples in_valid = 1.
REQ-025 SHALL, if reset asserts mid-stream, drop the in-flight data, with out_valid = 0 immediately and no spurious valid after release.

Verification
REQ-026 SHALL cover: NUM_SHARES=2, theta shares (2'b10, 2'b01) so theta = 11 (one), a0d = 4'h5, a1d = 4'hA, random = 0, in_valid = 1 -> after 1 edge, unmasked output = 8'h5A and out_valid = 1.
REQ-027 SHALL cover: theta unmasked = 00 with any mul inputs and random inputs -> unmasked output = 8'h00.
REQ-028 SHALL cover: theta unmasked = 11 with random in_random and random input masks over 1000 cycles -> unmasked output equals {a0d, a1d} every cycle.
REQ-029 SHALL cover: the in_valid pattern 1,1,0,1 -> out_valid = 1,1,0,1, delayed by one cycle, with output data matching the order of inputs.
REQ-030 SHALL cover: in_reset pulsed low between edges while out_valid = 1 -> out_valid and all output shares go to 0 without waiting for a clock edge.
REQ-031 SHALL cover: NUM_SHARES=3 with a reference-model comparison of all 256 (a0d, a1d) pairs times 4 theta values -> zero mismatches.

Source files
------------

// File: rtl/masked_bv8_inv_stage3_hpc3.sv
// Third stage of a masked GF(2^8) inversion: lifts the GF(2^2) theta into GF(2^4)
// and multiplies it into both stage-2 products with two HPC3 masked multipliers.
module masked_bv8_inv_stage3_hpc3 #(
    parameter int NUM_SHARES = 2,
    localparam int NUM_QUAD = NUM_SHARES * (NUM_SHARES - 1) / 2,
    localparam int NUM_RANDOM = 3 * 4 * NUM_QUAD
) (
    input  logic                             in_clock,
    input  logic                             in_reset,
    input  logic                             in_valid,
    input  logic [NUM_SHARES-1:0][1:0]       in_theta_t2,
    input  logic [NUM_SHARES-1:0][3:0]       in_mul_a0_t2,
    input  logic [NUM_SHARES-1:0][3:0]       in_mul_a1_t2,
    input  logic [NUM_RANDOM-1:0]            in_random,
    output logic [NUM_SHARES-1:0][7:0]       out_inv_t3,
    output logic                             out_valid
);

    // GF(2^2) multiply in normal basis (W^2, W)
    function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    // Scale by N = W^2
    function automatic logic [1:0] gf4_scl_n(input logic [1:0] x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    // GF(2^4) multiply in normal basis (Z^4, Z) over GF(2^2)
    function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] e;
        e = gf4_scl_n(gf4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {gf4_mul(x[3:2], y[3:2]) ^ e, gf4_mul(x[1:0], y[1:0]) ^ e};
    endfunction

    // Index of the unordered share pair {i, j} in the random fields
    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * NUM_SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    logic [NUM_QUAD-1:0][3:0]                           joint_r_s;
    logic [NUM_QUAD-1:0][3:0]                           right_p_s;
    logic [NUM_QUAD-1:0][3:0]                           left_p_s;
    logic [1:0][NUM_QUAD-1:0][3:0]                      mask_p_s;
    logic [1:0][NUM_SHARES-1:0][3:0]                    mul_in_s;
    logic [NUM_SHARES-1:0][3:0]                         theta4_s;
    logic [1:0][NUM_SHARES-1:0][NUM_SHARES-1:0][3:0]    term_next_s;
    logic [1:0][NUM_SHARES-1:0][NUM_SHARES-1:0][3:0]    comp_next_s;
    logic [1:0][NUM_SHARES-1:0][NUM_SHARES-1:0][3:0]    term_r;
    logic [1:0][NUM_SHARES-1:0][NUM_SHARES-1:0][3:0]    comp_r;

    assign joint_r_s   = in_random[4*NUM_QUAD-1:0];
    assign right_p_s   = in_random[8*NUM_QUAD-1:4*NUM_QUAD];
    assign left_p_s    = in_random[12*NUM_QUAD-1:8*NUM_QUAD];
    assign mask_p_s[0] = left_p_s;
    assign mask_p_s[1] = right_p_s;
    assign mul_in_s[0] = in_mul_a0_t2;
    assign mul_in_s[1] = in_mul_a1_t2;

    // Share-wise subfield embedding of theta into GF(2^4)
    always_comb begin
        theta4_s = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            theta4_s[i] = {in_theta_t2[i], in_theta_t2[i]};
        end
    end

    // HPC3 partial products; ~x (x) r equals x (x) r + r because 4'b1111 is one
    always_comb begin
        term_next_s = '0;
        comp_next_s = '0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NUM_SHARES; i++) begin
                for (int j = 0; j < NUM_SHARES; j++) begin
                    if (i == j) begin
                        term_next_s[m][i][j] = gf16_mul(mul_in_s[m][i], theta4_s[i]);
                        comp_next_s[m][i][j] = 4'h0;
                    end else begin
                        term_next_s[m][i][j] = gf16_mul(mul_in_s[m][i],
                                                   theta4_s[j] ^ joint_r_s[pair_idx(i, j)])
                                               ^ mask_p_s[m][pair_idx(i, j)];
                        comp_next_s[m][i][j] = gf16_mul(~mul_in_s[m][i], joint_r_s[pair_idx(i, j)])
                                               ^ mask_p_s[m][pair_idx(i, j)];
                    end
                end
            end
        end
    end

    // Domain-separating register stage, clocked every cycle
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            term_r    <= '0;
            comp_r    <= '0;
            out_valid <= 1'b0;
        end else begin
            term_r    <= term_next_s;
            comp_r    <= comp_next_s;
            out_valid <= in_valid;
        end
    end

    // Per-share compression of registered terms; b1 (from a0) in the high nibble
    always_comb begin
        out_inv_t3 = '0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NUM_SHARES; i++) begin
                for (int j = 0; j < NUM_SHARES; j++) begin
                    out_inv_t3[i][4*(1-m) +: 4] = out_inv_t3[i][4*(1-m) +: 4]
                                                  ^ term_r[m][i][j] ^ comp_r[m][i][j];
                end
            end
        end
    end

endmodule
